// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the sequential multiplier.
interface mult_seq_ctrl_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32->64 shift-add multiplier sharing one ripple-carry adder.
// Define MULT_SIGNED_EN to build the two's-complement path (ABS/NEG states).
module fulladderN #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         Overflow
);
    logic c;
    logic c_msb;

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        c     = cin;
        c_msb = 1'b0;
        s     = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ c;
            c_msb = c;
            c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout     = c;
        Overflow = c ^ c_msb;
    end
endmodule

module mult_seq_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_ctrl_if.slave  bus
);
`ifdef MULT_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_RUN    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_m;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_product;
`ifdef MULT_SIGNED_EN
    logic        r_sgn;
    logic        r_nc;
    logic        r_op_signed;
`else
    logic        w_unused_is_signed;
    assign w_unused_is_signed = bus.is_signed;
`endif

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_cin;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_unused_ovf;

    fulladderN #(.N(32)) u_adder (
        .a        (w_add_a),
        .b        (w_add_b),
        .cin      (w_add_cin),
        .s        (w_sum),
        .cout     (w_cout),
        .Overflow (w_unused_ovf)
    );

    // Adder operand/carry-in steering; negation is ~x + cin with b tied low.
    always_comb begin
        w_add_a   = 32'd0;
        w_add_b   = 32'd0;
        w_add_cin = 1'b0;
        case (r_state)
`ifdef MULT_SIGNED_EN
            S_ABS_A: begin
                w_add_a   = ~r_m;
                w_add_cin = 1'b1;
            end
            S_ABS_B, S_NEG_LO: begin
                w_add_a   = ~r_p_lo;
                w_add_cin = 1'b1;
            end
            S_NEG_HI: begin
                w_add_a   = ~r_p_hi;
                w_add_cin = r_nc;
            end
`endif
            S_RUN: begin
                w_add_a = r_p_hi;
                if (r_p_lo[0]) begin
                    w_add_b = r_m;
                end else begin
                    w_add_b = 32'd0;
                end
            end
            default: begin
                w_add_a   = 32'd0;
                w_add_b   = 32'd0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    // Control FSM and datapath registers; busy/done/product are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_m         <= 32'd0;
            r_p_hi      <= 32'd0;
            r_p_lo      <= 32'd0;
            r_cnt       <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_product   <= 64'd0;
`ifdef MULT_SIGNED_EN
            r_sgn       <= 1'b0;
            r_nc        <= 1'b0;
            r_op_signed <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m    <= bus.op_a;
                        r_p_lo <= bus.op_b;
                        r_p_hi <= 32'd0;
                        r_cnt  <= 5'd0;
                        r_busy <= 1'b1;
`ifdef MULT_SIGNED_EN
                        r_sgn       <= bus.op_a[31] ^ bus.op_b[31];
                        r_op_signed <= bus.is_signed;
                        r_state     <= bus.is_signed ? S_ABS_A : S_RUN;
`else
                        r_state <= S_RUN;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                S_ABS_A: begin
                    if (r_m[31]) begin
                        r_m <= w_sum;
                    end
                    r_state <= S_ABS_B;
                end
                S_ABS_B: begin
                    if (r_p_lo[31]) begin
                        r_p_lo <= w_sum;
                    end
                    r_state <= S_RUN;
                end
`endif
                S_RUN: begin
                    // Adder carry becomes the new MSB of the shifted partial product.
                    r_p_hi <= {w_cout, w_sum[31:1]};
                    r_p_lo <= {w_sum[0], r_p_lo[31:1]};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
`ifdef MULT_SIGNED_EN
                        if (r_op_signed) begin
                            r_state <= S_NEG_LO;
                        end else begin
                            r_product <= {w_cout, w_sum, r_p_lo[31:1]};
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
`else
                        r_product <= {w_cout, w_sum, r_p_lo[31:1]};
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                S_NEG_LO: begin
                    if (r_sgn) begin
                        r_p_lo <= w_sum;
                        r_nc   <= w_cout;
                    end else begin
                        r_nc   <= 1'b0;
                    end
                    r_state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    if (r_sgn) begin
                        r_p_hi    <= w_sum;
                        r_product <= {w_sum, r_p_lo};
                    end else begin
                        r_product <= {r_p_hi, r_p_lo};
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (signed vectors need MULT_SIGNED_EN).
module tb_mult_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mult_seq_ctrl_if u_if ();

    mult_seq_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp_v);
        end
    endtask

    // Cycle c is the interval after the c-th edge following the accept edge.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp_p,
                          input bit pulse);
        int done_cyc;
        int n_done;
        @(negedge clk);
        u_if.start     = 1'b1;
        u_if.is_signed = sgn;
        u_if.op_a      = a;
        u_if.op_b      = b;
        @(negedge clk);
        u_if.start = 1'b0;
        done_cyc   = 0;
        n_done     = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) check_eq({tag, "_busy_c1"}, {63'd0, u_if.busy}, 64'd1);
            if (u_if.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
                check_eq({tag, "_busy_with_done"}, {63'd0, u_if.busy}, 64'd0);
            end
            if (pulse && (c == 5 || c == 33)) begin
                u_if.start = 1'b1;
                u_if.op_a  = 32'd9;
                u_if.op_b  = 32'd9;
            end else begin
                u_if.start = 1'b0;
            end
        end
        check_eq({tag, "_done_cycle"}, 64'(done_cyc), 64'(lat));
        check_eq({tag, "_done_count"}, 64'(n_done), 64'd1);
        check_eq({tag, "_product"}, u_if.product, exp_p);
        check_eq({tag, "_busy_after"}, {63'd0, u_if.busy}, 64'd0);
    endtask

    initial begin
        int n_done;
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        u_if.start     = 1'b0;
        u_if.is_signed = 1'b0;
        u_if.op_a      = 32'd0;
        u_if.op_b      = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {63'd0, u_if.busy}, 64'd0);
        check_eq("rst_done", {63'd0, u_if.done}, 64'd0);
        check_eq("rst_product", u_if.product, 64'd0);
        rst_n = 1'b1;

        run_op("u3x5", 1'b0, 32'd3, 32'd5, 33, 64'h0000_0000_0000_000F, 1'b0);
        run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("umsb", 1'b0, 32'h8000_0000, 32'd2, 33, 64'h0000_0001_0000_0000, 1'b0);
        run_op("umix", 1'b0, 32'h0000_FFFF, 32'h0001_0001, 33, 64'h0000_0000_FFFF_FFFF, 1'b0);
        run_op("uzero", 1'b0, 32'd0, 32'hDEAD_BEEF, 33, 64'd0, 1'b0);
`ifdef MULT_SIGNED_EN
        run_op("s_m7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 37, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run_op("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 37, 64'h4000_0000_0000_0000, 1'b0);
        run_op("s_7xm6", 1'b1, 32'd7, 32'hFFFF_FFFA, 37, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run_op("s_m1x0", 1'b1, 32'hFFFF_FFFF, 32'd0, 37, 64'd0, 1'b0);
`else
        run_op("sig_ignored", 1'b1, 32'hFFFF_FFFF, 32'd2, 33, 64'h0000_0001_FFFF_FFFE, 1'b0);
`endif
        run_op("start_ignored", 1'b0, 32'd3, 32'd5, 33, 64'h0000_0000_0000_000F, 1'b1);

        // Abort an operation with reset partway through.
        @(negedge clk);
        u_if.start     = 1'b1;
        u_if.is_signed = 1'b0;
        u_if.op_a      = 32'd100;
        u_if.op_b      = 32'd100;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {63'd0, u_if.busy}, 64'd0);
        check_eq("abort_product", u_if.product, 64'd0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (u_if.done) n_done++;
        end
        check_eq("abort_no_done", 64'(n_done), 64'd0);
        run_op("after_abort", 1'b0, 32'd2, 32'd2, 33, 64'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
